// File: rtl/rr_arb_mux_4.sv
// Four-channel round-robin arbiter feeding a single registered output entry.
// The winning word and its channel index are held until drained through y_vld/y_rdy.
module rr_arb_mux_4 #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d0,
   input  logic [W-1:0] d1,
   input  logic [W-1:0] d2,
   input  logic [W-1:0] d3,
   input  logic [3:0]   vld,
   output logic [3:0]   rdy,
   output logic [W-1:0] y,
   output logic [1:0]   y_idx,
   output logic         y_vld,
   input  logic         y_rdy
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   y_q, y_d;
   logic [1:0]     idx_q, idx_d;
   logic [1:0]     ptr_q, ptr_d;

   logic           loadEn;
   logic           found;
   logic           grant;
   logic [1:0]     cand;
   logic [1:0]     winner;
   logic [W-1:0]   dSel;

   // Scan from the priority pointer; reset suppresses any grant so nothing is lost silently.
   always_comb begin
      loadEn = (state_q == EMPTY) || y_rdy;
      found  = 1'b0;
      cand   = 2'd0;
      winner = 2'd0;
      for (int k = 0; k < 4; k++) begin
         cand = ptr_q + 2'(k);
         if (!found && vld[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
      grant = loadEn && found && !rst;
      rdy   = grant ? (4'b0001 << winner) : 4'b0000;
      case (winner)
         2'd0:    dSel = d0;
         2'd1:    dSel = d1;
         2'd2:    dSel = d2;
         default: dSel = d3;
      endcase
   end

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      if (grant) begin
         state_d = FULL;
         y_d     = dSel;
         idx_d   = winner;
         ptr_d   = winner + 2'd1;
      end else if (state_q == FULL && y_rdy) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         y_q     <= '0;
         idx_q   <= 2'd0;
         ptr_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
      end
   end

   assign y     = y_q;
   assign y_idx = idx_q;
   assign y_vld = (state_q == FULL);

endmodule

// File: tb/tb_rr_arb_mux_4.sv
// Directed bench for rr_arb_mux_4: each expected grant is queued when issued and a
// monitor pops and compares it whenever the output handshakes downstream.
module tb_rr_arb_mux_4;

   logic       clk;
   logic       rst;
   logic [3:0] d0, d1, d2, d3;
   logic [3:0] vld;
   logic [3:0] rdy;
   logic [3:0] y;
   logic [1:0] y_idx;
   logic       y_vld;
   logic       y_rdy;

   int checks   = 0;
   int failures = 0;

   // Expected entries, packed as {idx[1:0], data[3:0]}
   logic [5:0] expQ[$];

   rr_arb_mux_4 #(.W(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .d0    (d0),
      .d1    (d1),
      .d2    (d2),
      .d3    (d3),
      .vld   (vld),
      .rdy   (rdy),
      .y     (y),
      .y_idx (y_idx),
      .y_vld (y_vld),
      .y_rdy (y_rdy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // One cycle: drive inputs, check rdy mid-cycle, queue the word expected to be granted.
   task automatic applyStimulus(input logic rstIn, input logic [3:0] vldIn,
                                input logic yRdyIn, input logic [3:0] expRdy,
                                input logic [3:0] expData);
      logic [1:0] expIdx;
      rst   = rstIn;
      vld   = vldIn;
      y_rdy = yRdyIn;
      @(negedge clk);
      checkOutput("rdy", 32'(rdy), 32'(expRdy));
      if (expRdy != 4'b0000) begin
         case (expRdy)
            4'b0001: expIdx = 2'd0;
            4'b0010: expIdx = 2'd1;
            4'b0100: expIdx = 2'd2;
            default: expIdx = 2'd3;
         endcase
         expQ.push_back({expIdx, expData});
      end
      @(posedge clk);
      #1;
   endtask

   // Every downstream handshake must match the oldest outstanding expectation.
   always @(negedge clk) begin
      logic [5:0] e;
      if (y_vld === 1'b1 && y_rdy === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_output", 32'(y_vld), 32'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput("y", 32'(y), 32'(e[3:0]));
            checkOutput("y_idx", 32'(y_idx), 32'(e[5:4]));
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; vld = 4'b1111; y_rdy = 1'b1;
      d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;

      // Reset with full requests: nothing granted, outputs cleared.
      applyStimulus(1'b1, 4'b1111, 1'b1, 4'b0000, 4'h0);
      applyStimulus(1'b1, 4'b1111, 1'b1, 4'b0000, 4'h0);
      checkOutput("reset_y_vld", 32'(y_vld), 32'd0);
      checkOutput("reset_y", 32'(y), 32'd0);
      checkOutput("reset_y_idx", 32'(y_idx), 32'd0);

      // Round robin under full load.
      applyStimulus(1'b0, 4'b1111, 1'b1, 4'b0001, 4'hA);
      applyStimulus(1'b0, 4'b1111, 1'b1, 4'b0010, 4'hB);
      checkOutput("rr_y_vld", 32'(y_vld), 32'd1);
      applyStimulus(1'b0, 4'b1111, 1'b1, 4'b0100, 4'hC);
      applyStimulus(1'b0, 4'b1111, 1'b1, 4'b1000, 4'hD);
      checkOutput("rr_y_vld", 32'(y_vld), 32'd1);
      applyStimulus(1'b0, 4'b1111, 1'b1, 4'b0001, 4'hA);

      // Reset back to ptr=0 (last word drains during the reset cycle).
      applyStimulus(1'b1, 4'b0000, 1'b1, 4'b0000, 4'h0);

      // Sparse requests skip idle channels; ptr wraps 3 -> 0.
      d1 = 4'h5; d3 = 4'h9;
      applyStimulus(1'b0, 4'b1010, 1'b1, 4'b0010, 4'h5);
      applyStimulus(1'b0, 4'b1010, 1'b1, 4'b1000, 4'h9);
      applyStimulus(1'b0, 4'b1010, 1'b1, 4'b0010, 4'h5);
      applyStimulus(1'b0, 4'b1010, 1'b1, 4'b1000, 4'h9);
      applyStimulus(1'b0, 4'b0001, 1'b1, 4'b0001, 4'hA);

      // Backpressure: ptr=1 here, fill from channel 2 then stall.
      d1 = 4'hB; d2 = 4'h7; d3 = 4'hD;
      applyStimulus(1'b0, 4'b0100, 1'b1, 4'b0100, 4'h7);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 4'b1111, 1'b0, 4'b0000, 4'h0);
         checkOutput("hold_y", 32'(y), 32'h7);
         checkOutput("hold_y_idx", 32'(y_idx), 32'd2);
      end
      checkOutput("hold_y_vld", 32'(y_vld), 32'd1);
      applyStimulus(1'b0, 4'b1111, 1'b1, 4'b1000, 4'hD);

      // Drain to empty: ptr stays at 2 across idle cycles.
      applyStimulus(1'b0, 4'b0010, 1'b1, 4'b0010, 4'hB);
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 4'h0);
      checkOutput("drain_y_vld", 32'(y_vld), 32'd0);
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 4'h0);
      checkOutput("idle_y_vld", 32'(y_vld), 32'd0);
      d2 = 4'hC;
      applyStimulus(1'b0, 4'b1111, 1'b0, 4'b0100, 4'hC);

      // Reset while FULL, stalled, ptr=3: held entry is discarded.
      applyStimulus(1'b1, 4'b1111, 1'b0, 4'b0000, 4'h0);
      expQ.delete();
      checkOutput("midreset_y_vld", 32'(y_vld), 32'd0);
      checkOutput("midreset_y_idx", 32'(y_idx), 32'd0);
      applyStimulus(1'b0, 4'b1111, 1'b1, 4'b0001, 4'hA);
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 4'h0);
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 4'h0);
      checkOutput("final_y_vld", 32'(y_vld), 32'd0);
      checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rr_arb_mux_4.md
# rr_arb_mux_4

Four-channel round-robin arbiter with a registered output. It sits directly upstream of the 4:1 indexed data mux stage. It also absorbs the multi-source contention that the plain mux cannot handle. Each of four valid/ready sources offers a W-bit word, and the block grants one source per cycle by rotating priority. The block captures the winning word, together with its source index, into a single output register drained through a valid/ready handshake.

## Interface
- W, default 4, width of each data word.
- clk  input  1  rising-edge clock; sole clock.
- rst  input  1  reset, synchronous, active-high.
- d0, d1, d2, d3  input  W  source data words, channel 0..3.
- vld  input  4  vld[i] = channel i offers d<i> this cycle.
- rdy  output  4  rdy[i] = channel i's word is accepted this cycle (one-hot or zero).
- y  output  W  registered output word.
- y_idx  output  2  channel index that supplied y.
- y_vld  output  1  y / y_idx hold a valid entry.
- y_rdy  input  1  downstream accepts y this cycle.

## Operation
- Storage:
  - one output entry: y, y_idx, y_vld;
  - a 2-bit priority pointer ptr, the highest-priority channel for the next grant.
- States:
  - EMPTY (y_vld=0);
  - FULL (y_vld=1).
- load_en = !y_vld || y_rdy. The register is empty or is draining this cycle.
- Arbitration (combinational), when load_en=1 and vld!=0:
  - winner = first i with vld[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4);
  - rdy[winner]=1; all other rdy=0;
  - when load_en=0 or vld=0, rdy=4'b0000.
- On a grant, at the next edge:
  - y <= d[winner];
  - y_idx <= winner;
  - y_vld <= 1;
  - ptr <= winner+1 (mod 4, natural 2-bit wrap; 3+1 -> 0).
- No grant, with y_vld=1 and y_rdy=1: y_vld <= 0. y and y_idx hold their last value.
- No grant, with y_vld=0: nothing changes.
- FULL and y_rdy=0: y, y_idx, y_vld and ptr all hold; rdy=0.
- ptr changes only on a grant. Idle cycles do not rotate priority.
- Data is the selected word unmodified. No arithmetic is applied; width is W in and W out.
- A source must keep vld[i] and d<i> stable until it sees rdy[i]=1. The block does not check this.

## Timing
- Reset (rst=1 at a rising edge) forces:
  - y_vld=0;
  - y='0;
  - y_idx=0;
  - ptr=0.
- rdy=0 during any cycle with rst=1.
- Reset mid-transfer discards the held entry. Any word that would have been granted in the reset cycle is not accepted.
- Latency: a word accepted in cycle N (rdy[i]=1) appears on y with y_vld=1 in cycle N+1.
- Throughput: one word per cycle when y_rdy is held high.
- Simultaneous drain and load (FULL, y_rdy=1, vld!=0):
  - the new word replaces the old one at the same edge;
  - y_vld stays 1;
  - there is no bubble.
- rdy is combinational from vld, y_vld, y_rdy and ptr.
  - Sources must not make vld depend on rdy.
  - Downstream must not make y_rdy depend on rdy.
- y, y_idx and y_vld are registered outputs only. There is no combinational path from the inputs to them.
- Fairness: with all four channels continuously valid and y_rdy=1, the grant order is 0,1,2,3,0,... Every channel waits at most 3 grants.

## Test plan
- Reset:
  - stimulus: drive rst=1 for 2 cycles with vld=4'b1111 and y_rdy=1;
  - response: y_vld=0, y=0, y_idx=0 and rdy=0 throughout;
  - first grant after release goes to channel 0.
- Round-robin under full load:
  - stimulus: d0..d3 = 4'hA, 4'hB, 4'hC, 4'hD; vld=4'b1111; y_rdy=1;
  - response: y sequence A,B,C,D,A,... and y_idx 0,1,2,3,0, one per cycle, y_vld continuously 1.
- Sparse requests and pointer skip:
  - stimulus: from reset, vld=4'b1010 with d1=4'h5 and d3=4'h9;
  - response: grants go to 1, 3, 1, 3, ...;
  - then vld=4'b0001: the next grant is channel 0 (ptr wrapped 3 -> 0 after the grant to 3).
- Backpressure:
  - stimulus: fill with d2=4'h7 (vld=4'b0100), then y_rdy=0 for 5 cycles while vld=4'b1111;
  - response: y=7 and y_idx=2 are held, and rdy=0 for all 5 cycles;
  - when y_rdy rises, channel 3 is granted in the same cycle and y=d3 on the next cycle.
- Drain to empty:
  - stimulus: one word from channel 1, then vld=0 and y_rdy=1;
  - response: y_vld drops to 0 one cycle after the handshake;
  - ptr stays 2 (next grant with vld=4'b1111 goes to channel 2).
- Reset mid-operation:
  - stimulus: assert rst while y_vld=1, y_rdy=0 and ptr=3;
  - response: y_vld=0 and y_idx=0 on the next cycle;
  - ptr=0, so the subsequent grant with vld=4'b1111 goes to channel 0.
